trade_signal: RTL and testbench
===============================

# trade_signal

Downstream consumer of the byte-stream message parser. Takes each decoded trade (`field_valid` pulse with order id, price, volume), keeps a sliding window of the last 2^LOG2_WIN trade prices, and emits a mean-reversion order signal when a trade deviates from the window average by more than a threshold. The output is a valid/ready holding register. The input side never stalls, because the parser has no backpressure.

## Interface

Parameters:
- `LOG2_WIN`, default 3: window depth is 2^LOG2_WIN trades.
- `THRESH`, default 32'd100: deviation threshold, in price units.
- `MAX_QTY`, default 32'd1000: clip level for the emitted volume.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `field_valid`  in  1  one-cycle pulse; the parsed fields below are valid.
- `msg_type`  in  8  message type; only `MSG_TRADE` (8'h54) is processed.
- `order_id`  in  64  trade order id.
- `price`  in  32  unsigned trade price.
- `volume`  in  32  unsigned trade volume.
- `sig_valid`  out  1  signal register holds a pending order.
- `sig_ready`  in  1  downstream accepts the signal.
- `sig_side`  out  1  1 = BUY, 0 = SELL.
- `sig_order_id`  out  64  echo of the triggering trade's id.
- `sig_price`  out  32  triggering trade's price.
- `sig_volume`  out  32  min(volume, MAX_QTY).
- `avg_price`  out  32  running sum >> LOG2_WIN.
- `warm`  out  1  window has been filled at least once.
- `drop_count`  out  16  signals lost to a full output register; saturates at 16'hFFFF.

## Operation

Two-stage pipeline, accepting one trade per cycle with no stall.

**Stage A (capture):**
- On `field_valid && msg_type == MSG_TRADE`, register order_id, price and volume, and set the stage-A valid bit.
- Any other msg_type is ignored: no window update, no signal.

**Stage B (evaluate):** acts when stage A is valid, using the window state from *before* this trade.
- BUY when `warm && price + THRESH < avg`.
- SELL when `warm && price > avg + THRESH`.
- All compares are 33-bit so there is no overflow.
- Equality at either boundary produces no signal.
- In the same cycle, update the window:
  - `sum <= sum + price - (full ? buf[wr_ptr] : 0)`;
  - `buf[wr_ptr] <= price`;
  - `wr_ptr` increments and wraps at 2^LOG2_WIN;
  - `count` increments and saturates at 2^LOG2_WIN;
  - `full` (drives `warm`) sets when count reaches 2^LOG2_WIN.
- `sum` width is 32 + LOG2_WIN; no truncation until the shift.

**Output register:**
- A signal loads it when the register is empty, or when `sig_valid && sig_ready` in the same cycle.
- Otherwise the signal is dropped and `drop_count` increments (saturating).
- While `sig_valid` is high, the output fields hold stable until the handshake completes.

**Reset:**
- All outputs go to 0; `wr_ptr`, `count`, `sum` and the stage-A valid bit are cleared.
- Buffer contents need not reset, because `count = 0` masks them.
- Reset mid-operation discards any pending signal and restarts warm-up.

## Timing

- Latency: `field_valid` in cycle N → stage A registered at edge N+1 → `sig_valid`, `avg_price` and `warm` updated at edge N+2.
- Back-to-back `field_valid` pulses are all processed, one per cycle.
- `sig_valid` never drops without `sig_ready`.
- A handshake and a new load in the same cycle give `sig_valid` continuously high with the new fields.
- Asynchronous reset clears outputs immediately; first evaluation is possible 2 cycles after reset deassertion plus one `field_valid`.

## Structure

- Shared package `mkt_pkg` holds:
  - `MSG_TRADE = 8'h54`;
  - `typedef enum logic {SIDE_SELL, SIDE_BUY} side_t`;
  - `typedef struct packed {order_id, price, volume} trade_t`.
  The parser's type constant comes from the same package.
- One sub-module, `price_window`: the ring buffer, `wr_ptr`, `count`, running `sum` and `full`.
  - Inputs: push and price.
  - Outputs: sum and full.
- The top level holds stage A, the compare logic, the output register and the drop counter.

## Test plan

All scenarios use LOG2_WIN=2, THRESH=10, MAX_QTY=1000.

1. Warm-up: 4 trades at price 100 → no `sig_valid`; `warm` rises with the 4th trade's evaluation; `avg_price` = 100.
2. Buy: after (1), one trade at 85, id 0x0123456789ABCDEF → `sig_valid`, BUY, `sig_price` 85, id echoed; `avg_price` becomes 96 (385 >> 2).
3. Boundaries: window of four trades at 100, then 110 → no signal; next 111 → SELL (average before 111 is (100·3+110)/4 = 102, and 111 > 112 is false, so the bench first refills with 100s, then 111 → SELL).
4. Backpressure: `sig_ready` = 0, two triggering trades 1 cycle apart → first held with fields stable, second dropped, `drop_count` = 1; raise `sig_ready` → exactly one handshake, then `sig_valid` = 0.
5. Filtering and clipping: `msg_type` 8'h41 with `field_valid` → window count unchanged; triggering trade with volume 5000 → `sig_volume` 1000.
6. Reset mid-operation: assert `rst` while `sig_valid` = 1 → `sig_valid`, `warm`, `avg_price` and `drop_count` all 0 with no clock edge; warm-up restarts from an empty window.

Source files
------------

// File: rtl/mkt_pkg.sv
// Shared market-data types: message codes, order side and the decoded trade record.
package mkt_pkg;

  localparam logic [7:0] MSG_TRADE = 8'h54;

  typedef enum logic {
    SIDE_SELL = 1'b0,
    SIDE_BUY  = 1'b1
  } side_t;

  typedef struct packed {
    logic [63:0] order_id;
    logic [31:0] price;
    logic [31:0] volume;
  } trade_t;

  function automatic logic [31:0] clip_qty(input logic [31:0] v, input logic [31:0] max_q);
    return (v > max_q) ? max_q : v;
  endfunction

endpackage

// File: rtl/price_window.sv
// Sliding window of the last 2^LOG2_WIN prices with a running sum; one push per cycle,
// sum/full reflect all pushes up to the previous edge; never stalls.
module price_window #(
  parameter int LOG2_WIN = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [31:0]           price,
  output logic [32+LOG2_WIN-1:0] sum,
  output logic                  full
);

  localparam int DEPTH = 1 << LOG2_WIN;
  localparam int SUM_W = 32 + LOG2_WIN;
  localparam logic [LOG2_WIN:0] CNT_MAX = (LOG2_WIN + 1)'(DEPTH);

  logic [31:0]         ring [DEPTH];
  logic [LOG2_WIN-1:0] wr_ptr;
  logic [LOG2_WIN:0]   count;
  logic [SUM_W-1:0]    oldest;

  assign full = (count == CNT_MAX);

  // Until the window is full the slot being overwritten holds stale data, so it must not be subtracted.
  assign oldest = full ? {{LOG2_WIN{1'b0}}, ring[wr_ptr]} : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      count  <= '0;
      sum    <= '0;
    end else if (push) begin
      sum    <= sum + {{LOG2_WIN{1'b0}}, price} - oldest;
      wr_ptr <= wr_ptr + 1'b1;
      if (count != CNT_MAX)
        count <= count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      ring[wr_ptr] <= price;
  end

endmodule

// File: rtl/trade_signal.sv
// Mean-reversion signal generator: trade capture, window compare, valid/ready output register.
// Latency 2 cycles from field_valid to sig_valid; input never stalls, signals are dropped when the output is full.
module trade_signal
  import mkt_pkg::*;
#(
  parameter int          LOG2_WIN = 3,
  parameter logic [31:0] THRESH   = 32'd100,
  parameter logic [31:0] MAX_QTY  = 32'd1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        field_valid,
  input  logic [7:0]  msg_type,
  input  logic [63:0] order_id,
  input  logic [31:0] price,
  input  logic [31:0] volume,
  output logic        sig_valid,
  input  logic        sig_ready,
  output logic        sig_side,
  output logic [63:0] sig_order_id,
  output logic [31:0] sig_price,
  output logic [31:0] sig_volume,
  output logic [31:0] avg_price,
  output logic        warm,
  output logic [15:0] drop_count
);

  localparam int SUM_W = 32 + LOG2_WIN;

  trade_t           a_trade;
  logic             a_vld;
  logic             capture;
  logic [SUM_W-1:0] win_sum;
  logic             win_full;
  logic [32:0]      px33;
  logic [32:0]      avg33;
  logic [32:0]      th33;
  logic             buy;
  logic             sell;
  logic             fire;
  logic             load;
  logic             drop;

  assign capture = field_valid && (msg_type == MSG_TRADE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_vld   <= 1'b0;
      a_trade <= '0;
    end else begin
      a_vld <= capture;
      if (capture)
        a_trade <= '{order_id: order_id, price: price, volume: volume};
    end
  end

  price_window #(.LOG2_WIN(LOG2_WIN)) u_window (
    .clk   (clk),
    .rst   (rst),
    .push  (a_vld),
    .price (a_trade.price),
    .sum   (win_sum),
    .full  (win_full)
  );

  assign avg_price = win_sum[SUM_W-1:LOG2_WIN];
  assign warm      = win_full;

  // Window state here is pre-update, so the trade is judged against the average that excludes it.
  assign px33  = {1'b0, a_trade.price};
  assign avg33 = {1'b0, avg_price};
  assign th33  = {1'b0, THRESH};
  assign buy   = win_full && ((px33 + th33) < avg33);
  assign sell  = win_full && (px33 > (avg33 + th33));

  assign fire = a_vld && (buy || sell);
  assign load = fire && (!sig_valid || sig_ready);
  assign drop = fire && !load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_valid    <= 1'b0;
      sig_side     <= 1'b0;
      sig_order_id <= '0;
      sig_price    <= '0;
      sig_volume   <= '0;
    end else if (load) begin
      sig_valid    <= 1'b1;
      sig_side     <= buy ? SIDE_BUY : SIDE_SELL;
      sig_order_id <= a_trade.order_id;
      sig_price    <= a_trade.price;
      sig_volume   <= clip_qty(a_trade.volume, MAX_QTY);
    end else if (sig_ready) begin
      sig_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      drop_count <= '0;
    else if (drop && (drop_count != 16'hFFFF))
      drop_count <= drop_count + 16'd1;
  end

endmodule

// File: tb/tb_trade_signal.sv
// Directed scenarios then random traffic, each cycle compared with a queue-based window model.
module tb_trade_signal;

  localparam int WIN = 4;
  localparam longint TH = 10;
  localparam longint MAXQ = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        field_valid;
  logic [7:0]  msg_type;
  logic [63:0] order_id;
  logic [31:0] price;
  logic [31:0] volume;
  logic        sig_valid;
  logic        sig_ready;
  logic        sig_side;
  logic [63:0] sig_order_id;
  logic [31:0] sig_price;
  logic [31:0] sig_volume;
  logic [31:0] avg_price;
  logic        warm;
  logic [15:0] drop_count;

  trade_signal #(.LOG2_WIN(2), .THRESH(32'd10), .MAX_QTY(32'd1000)) dut (
    .clk(clk), .rst(rst), .field_valid(field_valid), .msg_type(msg_type),
    .order_id(order_id), .price(price), .volume(volume),
    .sig_valid(sig_valid), .sig_ready(sig_ready), .sig_side(sig_side),
    .sig_order_id(sig_order_id), .sig_price(sig_price), .sig_volume(sig_volume),
    .avg_price(avg_price), .warm(warm), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int hs_count = 0;

  // Reference model: trade history as a queue, output register as plain variables.
  longint unsigned win[$];
  bit          m_vld;
  bit          m_side;
  logic [63:0] m_id;
  longint      m_price;
  longint      m_vol;
  int          m_drops;
  bit          ma_vld;
  logic [63:0] ma_id;
  longint      ma_price;
  longint      ma_vol;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint win_avg();
    longint s = 0;
    foreach (win[i]) s += longint'(win[i]);
    return s / WIN;
  endfunction

  task automatic model_reset();
    win.delete();
    m_vld = 0; m_side = 0; m_id = '0; m_price = 0; m_vol = 0; m_drops = 0;
    ma_vld = 0;
  endtask

  task automatic model_edge(input bit rdy);
    bit hs;
    bit is_warm;
    bit buy;
    bit sell;
    longint avg;
    hs = m_vld && rdy;
    if (ma_vld) begin
      avg = win_avg();
      is_warm = (win.size() == WIN);
      buy  = is_warm && (ma_price + TH < avg);
      sell = is_warm && (ma_price > avg + TH);
      if (buy || sell) begin
        if (!m_vld || rdy) begin
          m_vld = 1; m_side = buy; m_id = ma_id; m_price = ma_price;
          m_vol = (ma_vol > MAXQ) ? MAXQ : ma_vol;
        end else if (m_drops < 65535) begin
          m_drops++;
        end
      end else if (hs) begin
        m_vld = 0;
      end
      win.push_back(longint'(ma_price));
      if (win.size() > WIN) void'(win.pop_front());
    end else if (hs) begin
      m_vld = 0;
    end
  endtask

  task automatic check_all();
    chk("sig_valid", 64'(sig_valid), 64'(m_vld));
    if (m_vld) begin
      chk("sig_side", 64'(sig_side), 64'(m_side));
      chk("sig_order_id", sig_order_id, m_id);
      chk("sig_price", 64'(sig_price), 64'(m_price));
      chk("sig_volume", 64'(sig_volume), 64'(m_vol));
    end
    chk("avg_price", 64'(avg_price), 64'(win_avg()));
    chk("warm", 64'(warm), 64'(win.size() == WIN));
    chk("drop_count", 64'(drop_count), 64'(m_drops));
  endtask

  // Called at a falling edge: drive one cycle of inputs, advance model at the rising edge, check.
  task automatic step(input bit fv, input logic [7:0] mt, input logic [63:0] id,
                      input logic [31:0] pr, input logic [31:0] vol, input bit rdy);
    field_valid = fv; msg_type = mt; order_id = id; price = pr; volume = vol; sig_ready = rdy;
    if (sig_valid && rdy) hs_count++;
    @(posedge clk);
    model_edge(rdy);
    ma_vld = fv && (mt == 8'h54);
    ma_id = id; ma_price = longint'(pr); ma_vol = longint'(vol);
    @(negedge clk);
    check_all();
  endtask

  task automatic trade(input logic [31:0] pr, input bit rdy);
    step(1'b1, 8'h54, {32'hCAFE0000, pr}, pr, 32'd10, rdy);
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 8'h00, 64'd0, 32'd0, 32'd0, rdy);
  endtask

  initial begin
    rst = 1'b1;
    field_valid = 0; msg_type = 0; order_id = 0; price = 0; volume = 0; sig_ready = 0;
    model_reset();
    #1;
    chk("rst_sig_valid", 64'(sig_valid), 64'd0);
    chk("rst_avg", 64'(avg_price), 64'd0);
    chk("rst_warm", 64'(warm), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Warm-up
    for (int i = 0; i < 3; i++) trade(32'd100, 1'b0);
    trade(32'd100, 1'b0);
    chk("t1_not_warm_yet", 64'(warm), 64'd0);
    idle(1'b0);
    chk("t1_warm", 64'(warm), 64'd1);
    chk("t1_avg", 64'(avg_price), 64'd100);
    chk("t1_no_sig", 64'(sig_valid), 64'd0);

    // Buy
    step(1'b1, 8'h54, 64'h0123456789ABCDEF, 32'd85, 32'd40, 1'b0);
    idle(1'b0);
    chk("t2_vld", 64'(sig_valid), 64'd1);
    chk("t2_side", 64'(sig_side), 64'd1);
    chk("t2_price", 64'(sig_price), 64'd85);
    chk("t2_id", sig_order_id, 64'h0123456789ABCDEF);
    chk("t2_avg", 64'(avg_price), 64'd96);
    idle(1'b1);

    // Boundaries
    for (int i = 0; i < 4; i++) trade(32'd100, 1'b0);
    trade(32'd110, 1'b0);
    idle(1'b0);
    chk("t3_eq_nosig", 64'(sig_valid), 64'd0);
    chk("t3_avg", 64'(avg_price), 64'd102);
    for (int i = 0; i < 4; i++) trade(32'd100, 1'b0);
    trade(32'd111, 1'b0);
    idle(1'b0);
    chk("t3_sell_vld", 64'(sig_valid), 64'd1);
    chk("t3_sell_side", 64'(sig_side), 64'd0);
    chk("t3_sell_price", 64'(sig_price), 64'd111);
    idle(1'b1);

    // Backpressure: two back-to-back buys, second dropped
    hs_count = 0;
    trade(32'd85, 1'b0);
    trade(32'd80, 1'b0);
    idle(1'b0);
    chk("t4_held_vld", 64'(sig_valid), 64'd1);
    chk("t4_held_price", 64'(sig_price), 64'd85);
    chk("t4_drop", 64'(drop_count), 64'd1);
    idle(1'b0);
    chk("t4_stable_price", 64'(sig_price), 64'd85);
    idle(1'b1);
    idle(1'b1);
    chk("t4_one_hs", 64'(hs_count), 64'd1);
    chk("t4_cleared", 64'(sig_valid), 64'd0);

    // Filtering and clipping
    step(1'b1, 8'h41, 64'd7, 32'd0, 32'd0, 1'b0);
    idle(1'b0);
    chk("t5_avg_unchanged", 64'(avg_price), 64'd94);
    chk("t5_warm", 64'(warm), 64'd1);
    step(1'b1, 8'h54, 64'd99, 32'd50, 32'd5000, 1'b0);
    idle(1'b0);
    chk("t5_vld", 64'(sig_valid), 64'd1);
    chk("t5_clip", 64'(sig_volume), 64'd1000);

    // Reset mid-operation
    #2 rst = 1'b1;
    #1;
    chk("t6_vld", 64'(sig_valid), 64'd0);
    chk("t6_warm", 64'(warm), 64'd0);
    chk("t6_avg", 64'(avg_price), 64'd0);
    chk("t6_drop", 64'(drop_count), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) trade(32'd100, 1'b0);
    idle(1'b0);
    chk("t6_rewarm_warm", 64'(warm), 64'd0);
    chk("t6_rewarm_avg", 64'(avg_price), 64'd75);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0,
           ($urandom_range(0, 7) == 0) ? 8'h41 : 8'h54,
           {$urandom, $urandom},
           32'(70 + $urandom_range(0, 60)),
           32'($urandom_range(0, 2000)),
           $urandom_range(0, 1) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
